ccm_ctr_serializer: RTL and testbench

- Producer for the byte-stream input of ccm_ctr_top: drives input_data, input_en and input_last into ccm_ctr_top and honours its out_ready backpressure.
- Accepts 128-bit plaintext blocks from an upstream valid/ready source and emits them MSB byte first.
- Marks the final byte of a frame, which may be a partial block.
- Counts the bytes emitted per frame so the packet layer can size MIC and header fields.

---
 rtl/ccm_pkg.sv | 7 +
 rtl/ccm_blk_shift.sv | 36 +++
 rtl/ccm_ctr_serializer.sv | 68 ++++++
 tb/tb_ccm_ctr_serializer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ccm_pkg.sv
// ccm_pkg: shared widths and FSM encoding for the CCM CTR byte serializer
package ccm_pkg;
   localparam int AES_BLOCK_W     = 128;
   localparam int BYTE_W          = 8;
   localparam int BYTES_PER_BLOCK = AES_BLOCK_W / BYTE_W;
   typedef enum logic {IDLE, SEND} state_t;
endpackage

// File: rtl/ccm_blk_shift.sv
// ccm_blk_shift: loadable block shift register (MSB byte first) with remaining-byte down-counter
//   clk, reset (async active-low); load/load_data/load_rem capture a block; shift drops the head byte
//   head = current MSB byte, rem_zero = head is the final byte of the block
module ccm_blk_shift
   import ccm_pkg::*;
#(
   parameter int WIDTH       = BYTE_W,
   parameter int WIDTH_BLOCK = AES_BLOCK_W,
   parameter int WIDTH_NB    = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   load,
   input  logic [WIDTH_BLOCK-1:0] load_data,
   input  logic [WIDTH_NB-1:0]    load_rem,
   input  logic                   shift,
   output logic [WIDTH-1:0]       head,
   output logic                   rem_zero
);
   logic [WIDTH_BLOCK-1:0] shreg;
   logic [WIDTH_NB-1:0]    rem;
   assign head     = shreg[WIDTH_BLOCK-1 -: WIDTH];
   assign rem_zero = rem == '0;
   // load wins over shift so a block accepted on the final-byte edge replaces the drained one
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         shreg <= '0;
         rem   <= '0;
      end else if (load) begin
         shreg <= load_data;
         rem   <= load_rem;
      end else if (shift) begin
         shreg <= shreg << WIDTH;
         rem   <= rem_zero ? rem : rem - WIDTH_NB'(1);
      end
endmodule

// File: rtl/ccm_ctr_serializer.sv
// ccm_ctr_serializer: splits 128-bit blocks into an MSB-first byte stream for ccm_ctr_top
//   clk, reset (async active-low)
//   blk_data/blk_valid/blk_last/blk_nbytes/blk_ready: upstream block handshake (nbytes = valid bytes - 1 on last)
//   ccm_ready: downstream backpressure; input_data/input_en/input_last: byte stream
//   frame_bytes: saturating byte count of current/last frame; frame_done: pulse with input_last
module ccm_ctr_serializer
   import ccm_pkg::*;
#(
   parameter int WIDTH       = BYTE_W,
   parameter int WIDTH_BLOCK = AES_BLOCK_W,
   parameter int WIDTH_NB    = 4,
   parameter int WIDTH_FCNT  = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [WIDTH_BLOCK-1:0] blk_data,
   input  logic                   blk_valid,
   input  logic                   blk_last,
   input  logic [WIDTH_NB-1:0]    blk_nbytes,
   output logic                   blk_ready,
   input  logic                   ccm_ready,
   output logic [WIDTH-1:0]       input_data,
   output logic                   input_en,
   output logic                   input_last,
   output logic [WIDTH_FCNT-1:0]  frame_bytes,
   output logic                   frame_done
);
   state_t           state;
   logic             last_flag, fresh, rem_zero, emit, fin, acc;
   logic [WIDTH-1:0] head;
   assign emit      = state == SEND && ccm_ready;
   assign fin       = emit && rem_zero;
   assign blk_ready = reset && (state == IDLE || fin);
   assign acc       = blk_valid && blk_ready;
   ccm_blk_shift #(.WIDTH(WIDTH), .WIDTH_BLOCK(WIDTH_BLOCK), .WIDTH_NB(WIDTH_NB)) u_shift (
      .clk      (clk),
      .reset    (reset),
      .load     (acc),
      .load_data(blk_data),
      .load_rem (blk_last ? blk_nbytes : WIDTH_NB'(WIDTH_BLOCK / WIDTH - 1)),
      .shift    (emit),
      .head     (head),
      .rem_zero (rem_zero)
   );
   // fresh marks a finished frame: the next accept in IDLE clears the count, and a frame that
   // starts back-to-back on the final-byte edge restarts the count at 1 on its first byte
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state       <= IDLE;
         last_flag   <= 1'b0;
         fresh       <= 1'b0;
         input_data  <= '0;
         input_en    <= 1'b0;
         input_last  <= 1'b0;
         frame_done  <= 1'b0;
         frame_bytes <= '0;
      end else begin
         state       <= acc ? SEND : fin ? IDLE : state;
         last_flag   <= acc ? blk_last : last_flag;
         input_en    <= emit;
         input_last  <= fin && last_flag;
         frame_done  <= fin && last_flag;
         input_data  <= emit ? head : input_data;
         frame_bytes <= emit ? (fresh ? WIDTH_FCNT'(1) : &frame_bytes ? frame_bytes : frame_bytes + WIDTH_FCNT'(1))
                             : (acc && fresh ? '0 : frame_bytes);
         fresh       <= emit ? fin && last_flag : acc ? 1'b0 : fresh;
      end
endmodule

// File: tb/tb_ccm_ctr_serializer.sv
// tb_ccm_ctr_serializer: directed self-checking bench for ccm_ctr_serializer
module tb_ccm_ctr_serializer;
   logic         clk = 1'b0, reset = 1'b0;
   logic [127:0] blk_data = '0;
   logic         blk_valid = 1'b0, blk_last = 1'b0;
   logic [3:0]   blk_nbytes = '0;
   logic         blk_ready, ccm_ready = 1'b0;
   logic [7:0]   input_data;
   logic         input_en, input_last, frame_done;
   logic [15:0]  frame_bytes;
   int           n_checks = 0, n_fail = 0;

   always #5 clk = ~clk;

   ccm_ctr_serializer dut (
      .clk(clk), .reset(reset), .blk_data(blk_data), .blk_valid(blk_valid), .blk_last(blk_last),
      .blk_nbytes(blk_nbytes), .blk_ready(blk_ready), .ccm_ready(ccm_ready), .input_data(input_data),
      .input_en(input_en), .input_last(input_last), .frame_bytes(frame_bytes), .frame_done(frame_done)
   );

   function automatic logic [127:0] blk_of(input logic [7:0] b0, input logic [7:0] step);
      logic [127:0] d;
      logic [7:0]   v;
      v = b0;
      for (int k = 0; k < 16; k++) begin
         d[127-8*k -: 8] = v;
         v = v + step;
      end
      return d;
   endfunction

   // {en, last, done, data, frame_bytes}
   function automatic logic [26:0] obs();
      return {input_en, input_last, frame_done, input_data, frame_bytes};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic accept_block(input logic [127:0] d, input logic last, input logic [3:0] nb);
      logic r, ok;
      ok = 1'b0;
      blk_data = d; blk_last = last; blk_nbytes = nb; blk_valid = 1'b1;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         r = blk_ready;
         tick();
         ok = r;
      end
      blk_valid = 1'b0;
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL accept_timeout got no handshake want handshake within 100 cycles");
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({obs(), blk_ready} !== 28'h0) begin
         n_fail++; $display("FAIL reset_outputs got %h want 0", {obs(), blk_ready});
      end
      @(negedge clk) reset = 1'b1;
      tick();
      n_checks++;
      if ({obs(), blk_ready} !== 28'h1) begin
         n_fail++; $display("FAIL reset_release got %h want 1", {obs(), blk_ready});
      end
   endtask

   task automatic test_single();
      logic [26:0] want;
      logic [7:0]  e;
      ccm_ready = 1'b1;
      accept_block(blk_of(8'h00, 8'h11), 1'b1, 4'd15);
      for (int i = 0; i < 16; i++) begin
         tick();
         e = 8'(8'h11 * i);
         want = {1'b1, i == 15, i == 15, e, 16'(i + 1)};
         n_checks++;
         if (obs() !== want) begin
            n_fail++; $display("FAIL single_byte%0d got %h want %h", i, obs(), want);
         end
      end
      tick();
      n_checks++;
      if ({obs(), blk_ready} !== {3'b000, 8'hFF, 16'd16, 1'b1}) begin
         n_fail++; $display("FAIL single_idle got %h want %h", {obs(), blk_ready}, {3'b000, 8'hFF, 16'd16, 1'b1});
      end
   endtask

   task automatic test_back_to_back();
      logic [26:0] want;
      logic [7:0]  e;
      ccm_ready = 1'b1;
      fork
         begin
            accept_block(blk_of(8'h00, 8'h11), 1'b0, 4'd0);
            accept_block(blk_of(8'h10, 8'h01), 1'b0, 4'd0);
            accept_block(blk_of(8'hA0, 8'h01), 1'b1, 4'd4);
         end
         begin
            tick();
            n_checks++;
            if (frame_bytes !== 16'd0) begin
               n_fail++; $display("FAIL b2b_clear got %0d want 0", frame_bytes);
            end
            for (int i = 0; i < 37; i++) begin
               tick();
               e = i < 16 ? 8'(8'h11 * i) : i < 32 ? 8'(8'h10 + i - 16) : 8'(8'hA0 + i - 32);
               want = {1'b1, i == 36, i == 36, e, 16'(i + 1)};
               n_checks++;
               if (obs() !== want) begin
                  n_fail++; $display("FAIL b2b_byte%0d got %h want %h", i, obs(), want);
               end
            end
            tick();
            n_checks++;
            if ({input_en, input_last, frame_bytes, blk_ready} !== {2'b00, 16'd37, 1'b1}) begin
               n_fail++; $display("FAIL b2b_idle got %h want %h", {input_en, input_last, frame_bytes, blk_ready}, {2'b00, 16'd37, 1'b1});
            end
         end
      join
   endtask

   task automatic test_stall();
      logic        pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      logic [26:0] want;
      int          k;
      k = 0;
      ccm_ready = 1'b0;
      accept_block(blk_of(8'h00, 8'h11), 1'b1, 4'd15);
      for (int c = 0; c < 64 && k < 16; c++) begin
         ccm_ready = pat[c % 4];
         #1;
         n_checks++;
         if (blk_ready !== (ccm_ready && k == 15)) begin
            n_fail++; $display("FAIL stall_ready c%0d got %b want %b", c, blk_ready, ccm_ready && k == 15);
         end
         tick();
         if (ccm_ready) begin
            want = {1'b1, k == 15, k == 15, 8'(8'h11 * k), 16'(k + 1)};
            k++;
         end else
            want = {3'b000, 8'(8'h11 * (k - 1)), 16'(k)};
         n_checks++;
         if (obs() !== want) begin
            n_fail++; $display("FAIL stall_cycle%0d got %h want %h", c, obs(), want);
         end
      end
      n_checks++;
      if (k != 16) begin
         n_fail++; $display("FAIL stall_count got %0d want 16", k);
      end
      ccm_ready = 1'b1;
   endtask

   task automatic test_short();
      ccm_ready = 1'b1;
      accept_block(blk_of(8'hA5, 8'h00), 1'b1, 4'd0);
      tick();
      n_checks++;
      if (obs() !== {3'b111, 8'hA5, 16'd1}) begin
         n_fail++; $display("FAIL short_byte got %h want %h", obs(), {3'b111, 8'hA5, 16'd1});
      end
      tick();
      n_checks++;
      if ({input_en, input_last, frame_done, blk_ready} !== 4'b0001) begin
         n_fail++; $display("FAIL short_idle got %b want 0001", {input_en, input_last, frame_done, blk_ready});
      end
   endtask

   task automatic test_reset_mid();
      ccm_ready = 1'b1;
      accept_block(blk_of(8'h00, 8'h11), 1'b1, 4'd15);
      repeat (7) tick();
      n_checks++;
      if (obs() !== {3'b100, 8'h66, 16'd7}) begin
         n_fail++; $display("FAIL abort_byte7 got %h want %h", obs(), {3'b100, 8'h66, 16'd7});
      end
      #2 reset = 1'b0;
      #1;
      n_checks++;
      if ({obs(), blk_ready} !== 28'h0) begin
         n_fail++; $display("FAIL abort_async got %h want 0", {obs(), blk_ready});
      end
      repeat (2) begin
         tick();
         n_checks++;
         if ({input_en, input_last, frame_done} !== 3'b000) begin
            n_fail++; $display("FAIL abort_hold got %b want 000", {input_en, input_last, frame_done});
         end
      end
      @(negedge clk) reset = 1'b1;
   endtask

   task automatic test_frame_restart();
      logic [26:0] want;
      ccm_ready = 1'b1;
      accept_block(blk_of(8'h10, 8'h01), 1'b1, 4'd15);
      for (int i = 0; i < 16; i++) begin
         tick();
         want = {1'b1, i == 15, i == 15, 8'(8'h10 + i), 16'(i + 1)};
         n_checks++;
         if (obs() !== want) begin
            n_fail++; $display("FAIL restart_f1_byte%0d got %h want %h", i, obs(), want);
         end
      end
      repeat (2) begin
         tick();
         n_checks++;
         if (frame_bytes !== 16'd16) begin
            n_fail++; $display("FAIL restart_hold got %0d want 16", frame_bytes);
         end
      end
      accept_block(blk_of(8'h00, 8'h11), 1'b1, 4'd2);
      n_checks++;
      if (frame_bytes !== 16'd0) begin
         n_fail++; $display("FAIL restart_clear got %0d want 0", frame_bytes);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         want = {1'b1, i == 2, i == 2, 8'(8'h11 * i), 16'(i + 1)};
         n_checks++;
         if (obs() !== want) begin
            n_fail++; $display("FAIL restart_f2_byte%0d got %h want %h", i, obs(), want);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want end of test");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_stall();
      test_short();
      test_reset_mid();
      test_frame_restart();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
